// File: rtl/axi_wr_pkg.sv
// Shared types and AXI encodings for the AXI4 write-channel slave.
package axi_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wr_state_e;

    localparam logic [1:0] FIXED  = 2'd0;
    localparam logic [1:0] INCR   = 2'd1;
    localparam logic [1:0] WRAP   = 2'd2;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Combinational next-beat address and RAM range check for the current beat address.
module axi_wr_addr_gen
    import axi_wr_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_AWIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            burst,
    input  logic [2:0]            size,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  range_err
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] word_idx;

    always_comb begin
        step      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size;
        // FIXED and any errored encoding hold the address; the sum wraps naturally.
        next_addr = (burst == INCR) ? addr + step : addr;
        word_idx  = addr >> 2;
        range_err = (word_idx >> MEM_AWIDTH) != '0;
    end

endmodule

// File: rtl/axi_wr_slave_mem.sv
// AXI4 write slave: one AW, awlen+1 counted W beats committed to RAM, one B response.
module axi_wr_slave_mem
    import axi_wr_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AWIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [1:0]              s_axi_awburst,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic                    s_axi_bvalid,
    output logic [1:0]              s_axi_bresp,
    input  logic                    s_axi_bready,
    output logic                    s_axi_arready,
    output logic                    s_axi_rvalid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [MEM_AWIDTH-1:0]   mem_waddr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_wen
);

    wr_state_e             state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, next_addr;
    logic [7:0]            len_q, cnt_q;
    logic [1:0]            burst_q;
    logic [2:0]            size_q;
    logic                  err_q, range_err, req_err;
    logic                  aw_hs, w_hs, b_hs;

    axi_wr_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_AWIDTH (MEM_AWIDTH)
    ) u_addr_gen (
        .addr      (addr_q),
        .burst     (burst_q),
        .size      (size_q),
        .next_addr (next_addr),
        .range_err (range_err)
    );

    assign s_axi_arready = 1'b0;
    assign s_axi_rvalid  = 1'b0;
    assign s_axi_rdata   = '0;

    assign req_err = ((s_axi_awburst != FIXED) && (s_axi_awburst != INCR)) ||
                     (s_axi_awsize > 3'd2);

    always_comb begin
        s_axi_awready = (state == IDLE);
        s_axi_wready  = (state == DATA);
        s_axi_bvalid  = (state == RESP);
        s_axi_bresp   = ((state == RESP) && err_q) ? SLVERR : OKAY;

        aw_hs = s_axi_awvalid && s_axi_awready;
        w_hs  = s_axi_wvalid && s_axi_wready;
        b_hs  = s_axi_bvalid && s_axi_bready;

        state_nxt = state;
        case (state)
            IDLE:    if (aw_hs) state_nxt = DATA;
            DATA:    if (w_hs && (cnt_q == len_q)) state_nxt = RESP;
            RESP:    if (b_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Errored or out-of-range beats are consumed but never reach the RAM.
        mem_wen   = w_hs && !err_q && !range_err && (s_axi_wstrb != '0);
        mem_waddr = mem_wen ? addr_q[MEM_AWIDTH+1:2] : '0;
        mem_wdata = mem_wen ? s_axi_wdata : '0;
        mem_wstrb = mem_wen ? s_axi_wstrb : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (aw_hs) begin
                cnt_q <= '0;
                err_q <= req_err;
            end else if (w_hs) begin
                cnt_q <= cnt_q + 8'd1;
                if (range_err) err_q <= 1'b1;
            end
        end
    end

    // Request fields are only meaningful after an AW handshake, so they carry no reset.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            addr_q  <= s_axi_awaddr;
            len_q   <= s_axi_awlen;
            burst_q <= s_axi_awburst;
            size_q  <= s_axi_awsize;
        end else if (w_hs) begin
            addr_q  <= next_addr;
        end
    end

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Directed bench for axi_wr_slave_mem with a byte-strobed RAM model on the mem_* port.
module tb_axi_wr_slave_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] awaddr = '0;
    logic [1:0]  awburst = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready = 1'b0;
    logic        arready, rvalid;
    logic [31:0] rdata;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_wen;

    int checks = 0;
    int failures = 0;
    int wen_cnt = 0;
    int wen_base;
    logic [31:0] ram [0:255];

    axi_wr_slave_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_AWIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awburst(awburst), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bvalid(bvalid), .s_axi_bresp(bresp), .s_axi_bready(bready),
        .s_axi_arready(arready), .s_axi_rvalid(rvalid), .s_axi_rdata(rdata),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wen(mem_wen)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) begin
            wen_cnt <= wen_cnt + 1;
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) ram[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic aw(input logic [15:0] a, input logic [1:0] b, input logic [7:0] l, input logic [2:0] s);
        @(negedge clk);
        awaddr = a; awburst = b; awlen = l; awsize = s; awvalid = 1'b1;
        #1;
        checks++; if (awready !== 1'b1) begin failures++; $display("FAIL aw_ready actual=%0b expected=1", awready); end
        @(posedge clk);
        #1 awvalid = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] st, input logic exp_wen, input logic [7:0] exp_addr);
        @(negedge clk);
        wdata = d; wstrb = st; wvalid = 1'b1;
        #1;
        checks++; if (wready !== 1'b1) begin failures++; $display("FAIL w_ready actual=%0b expected=1", wready); end
        checks++; if (mem_wen !== exp_wen) begin failures++; $display("FAIL mem_wen data=%0h actual=%0b expected=%0b", d, mem_wen, exp_wen); end
        if (exp_wen) begin
            checks++; if (mem_waddr !== exp_addr) begin failures++; $display("FAIL mem_waddr actual=%0h expected=%0h", mem_waddr, exp_addr); end
            checks++; if (mem_wdata !== d) begin failures++; $display("FAIL mem_wdata actual=%0h expected=%0h", mem_wdata, d); end
        end else begin
            checks++; if ({mem_waddr, mem_wdata, mem_wstrb} !== 44'h0) begin failures++; $display("FAIL mem_idle_zero actual=%0h/%0h/%0h expected=0", mem_waddr, mem_wdata, mem_wstrb); end
        end
        @(posedge clk);
        #1 wvalid = 1'b0; wdata = '0; wstrb = '0;
    endtask

    task automatic resp(input logic [1:0] exp_resp);
        @(negedge clk);
        checks++; if (bvalid !== 1'b1) begin failures++; $display("FAIL b_valid actual=%0b expected=1", bvalid); end
        checks++; if (bresp !== exp_resp) begin failures++; $display("FAIL b_resp actual=%0b expected=%0b", bresp, exp_resp); end
        checks++; if ({awready, wready} !== 2'b00) begin failures++; $display("FAIL resp_ready actual=%0b expected=00", {awready, wready}); end
        bready = 1'b1;
        @(posedge clk);
        #1 bready = 1'b0;
        @(negedge clk);
        checks++; if ({awready, bvalid} !== 2'b10) begin failures++; $display("FAIL back_to_idle actual=%0b expected=10", {awready, bvalid}); end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #2;
        checks++; if ({awready, wready, bvalid, bresp, mem_wen, arready, rvalid} !== 8'b1000_0000) begin
            failures++; $display("FAIL reset_outputs actual=%b expected=10000000", {awready, wready, bvalid, bresp, mem_wen, arready, rvalid}); end
        checks++; if ({rdata, mem_waddr, mem_wdata, mem_wstrb} !== 76'h0) begin failures++; $display("FAIL reset_data actual=%0h expected=0", {rdata, mem_waddr, mem_wdata, mem_wstrb}); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        wvalid = 1'b1; wdata = 32'hBAD0BAD0; wstrb = 4'hF;
        #1;
        checks++; if ({wready, mem_wen} !== 2'b00) begin failures++; $display("FAIL idle_w_ignored actual=%b expected=00", {wready, mem_wen}); end
        @(posedge clk);
        #1 wvalid = 1'b0; wdata = '0; wstrb = '0;
    endtask

    task automatic test_single_beat();
        wen_base = wen_cnt;
        aw(16'h0010, 2'd1, 8'd0, 3'd2);
        beat(32'hDEADBEEF, 4'hF, 1'b1, 8'h04);
        resp(2'b00);
        checks++; if (ram[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_ram actual=%0h expected=deadbeef", ram[4]); end
        checks++; if (wen_cnt - wen_base !== 1) begin failures++; $display("FAIL single_wen_count actual=%0d expected=1", wen_cnt - wen_base); end
    endtask

    task automatic test_incr_gap();
        wen_base = wen_cnt;
        aw(16'h0100, 2'd1, 8'd3, 3'd2);
        beat(32'd1, 4'hF, 1'b1, 8'h40);
        beat(32'd2, 4'hF, 1'b1, 8'h41);
        repeat (2) begin
            @(negedge clk); #1;
            checks++; if ({wready, mem_wen, bvalid} !== 3'b100) begin failures++; $display("FAIL gap_stall actual=%b expected=100", {wready, mem_wen, bvalid}); end
        end
        beat(32'd3, 4'hF, 1'b1, 8'h42);
        beat(32'd4, 4'hF, 1'b1, 8'h43);
        resp(2'b00);
        for (int i = 0; i < 4; i++) begin
            checks++; if (ram[8'h40 + i] !== 32'(i + 1)) begin failures++; $display("FAIL incr_ram[%0d] actual=%0h expected=%0h", 8'h40 + i, ram[8'h40 + i], i + 1); end
        end
        checks++; if (wen_cnt - wen_base !== 4) begin failures++; $display("FAIL incr_wen_count actual=%0d expected=4", wen_cnt - wen_base); end
    endtask

    task automatic test_zero_strb_tail();
        wen_base = wen_cnt;
        aw(16'h0200, 2'd1, 8'd1, 3'd2);
        beat(32'h00000011, 4'hF, 1'b1, 8'h80);
        beat(32'h00000000, 4'h0, 1'b0, 8'h00);
        resp(2'b00);
        checks++; if (wen_cnt - wen_base !== 1) begin failures++; $display("FAIL tail_wen_count actual=%0d expected=1", wen_cnt - wen_base); end
    endtask

    task automatic test_errors();
        wen_base = wen_cnt;
        aw(16'h0020, 2'd2, 8'd1, 3'd2);
        beat(32'h12345678, 4'hF, 1'b0, 8'h00);
        beat(32'h9ABCDEF0, 4'hF, 1'b0, 8'h00);
        resp(2'b10);
        aw(16'h0000, 2'd1, 8'd0, 3'd3);
        beat(32'h00000099, 4'hF, 1'b0, 8'h00);
        resp(2'b10);
        checks++; if (wen_cnt - wen_base !== 0) begin failures++; $display("FAIL err_wen_count actual=%0d expected=0", wen_cnt - wen_base); end
        // Last in-range word, then the increment crosses past the RAM end.
        aw(16'h03FC, 2'd1, 8'd1, 3'd2);
        beat(32'h00000077, 4'hF, 1'b1, 8'hFF);
        beat(32'h00000088, 4'hF, 1'b0, 8'h00);
        resp(2'b10);
        checks++; if (ram[255] !== 32'h77) begin failures++; $display("FAIL range_ram actual=%0h expected=77", ram[255]); end
    endtask

    task automatic test_fixed();
        wen_base = wen_cnt;
        aw(16'h0008, 2'd0, 8'd2, 3'd2);
        beat(32'h0000000A, 4'hF, 1'b1, 8'h02);
        beat(32'h0000000B, 4'hF, 1'b1, 8'h02);
        beat(32'h0000000C, 4'hF, 1'b1, 8'h02);
        resp(2'b00);
        checks++; if (ram[2] !== 32'hC) begin failures++; $display("FAIL fixed_ram actual=%0h expected=c", ram[2]); end
        checks++; if (wen_cnt - wen_base !== 3) begin failures++; $display("FAIL fixed_wen_count actual=%0d expected=3", wen_cnt - wen_base); end
    endtask

    task automatic test_bready_hold();
        aw(16'h0030, 2'd1, 8'd0, 3'd2);
        beat(32'h00000030, 4'hF, 1'b1, 8'h0C);
        wvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        repeat (5) begin
            @(negedge clk); #1;
            checks++; if ({bvalid, bresp, awready, wready, mem_wen} !== 6'b100000) begin
                failures++; $display("FAIL bready_hold actual=%b expected=100000", {bvalid, bresp, awready, wready, mem_wen}); end
        end
        wvalid = 1'b0; wdata = '0; wstrb = '0;
        resp(2'b00);
    endtask

    task automatic test_reset_mid_burst();
        aw(16'h0000, 2'd1, 8'd7, 3'd2);
        beat(32'h00000031, 4'hF, 1'b1, 8'h00);
        beat(32'h00000032, 4'hF, 1'b1, 8'h01);
        @(negedge clk);
        wvalid = 1'b1; wdata = 32'h00000033; wstrb = 4'hF;
        #1 rst = 1'b0;
        #1;
        checks++; if ({awready, wready, bvalid, bresp, mem_wen} !== 6'b100000) begin
            failures++; $display("FAIL midburst_reset actual=%b expected=100000", {awready, wready, bvalid, bresp, mem_wen}); end
        checks++; if ({mem_waddr, mem_wdata, mem_wstrb} !== 44'h0) begin failures++; $display("FAIL midburst_mem actual=%0h expected=0", {mem_waddr, mem_wdata, mem_wstrb}); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; wvalid = 1'b0; wdata = '0; wstrb = '0;
        checks++; if (ram[2] !== 32'hC) begin failures++; $display("FAIL midburst_no_write actual=%0h expected=c", ram[2]); end
        aw(16'h0014, 2'd1, 8'd0, 3'd2);
        beat(32'h00000005, 4'hF, 1'b1, 8'h05);
        resp(2'b00);
        checks++; if (ram[5] !== 32'h5) begin failures++; $display("FAIL post_reset_ram actual=%0h expected=5", ram[5]); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_incr_gap();
        test_zero_strb_tail();
        test_errors();
        test_fixed();
        test_bready_hold();
        test_reset_mid_burst();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
